// File: rtl/vga_pkg.sv
// Shared VGA timing constants and the motion-scheduler state type.
package vga_pkg;
  localparam int COORD_W  = 10;
  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;

  typedef enum logic [1:0] {
    IDLE,
    STEP,
    DONE
  } sched_state_t;
endpackage

// File: rtl/square_axis_step.sv
// One-axis motion step for a square: advance by SPEED, or clamp and reverse at an edge.
module square_axis_step
  import vga_pkg::*;
#(
  parameter int SIZE  = 50,
  parameter int SPEED = 4,
  parameter int LIMIT = 640
) (
  input  logic [COORD_W-1:0] pos,
  input  logic               dir,
  output logic [COORD_W-1:0] pos_next,
  output logic               dir_next
);
  localparam int EXT_W = COORD_W + 1;
  localparam logic [EXT_W-1:0] SIZE_W  = EXT_W'(SIZE);
  localparam logic [EXT_W-1:0] SPEED_W = EXT_W'(SPEED);
  localparam logic [EXT_W-1:0] LIMIT_W = EXT_W'(LIMIT);

  // One guard bit so pos + SIZE + SPEED can never wrap.
  logic [EXT_W-1:0] pos_ext;
  assign pos_ext = {1'b0, pos};

  always_comb begin
    pos_next = pos;
    dir_next = dir;
    if (dir) begin
      if (pos_ext + SIZE_W + SPEED_W >= LIMIT_W) begin
        pos_next = COORD_W'(LIMIT - SIZE);
        dir_next = 1'b0;
      end else begin
        pos_next = COORD_W'(pos_ext + SPEED_W);
      end
    end else begin
      if (pos_ext < SPEED_W) begin
        pos_next = '0;
        dir_next = 1'b1;
      end else begin
        pos_next = COORD_W'(pos_ext - SPEED_W);
      end
    end
  end
endmodule

// File: rtl/square_motion_scheduler.sv
// Steps every square once per frame at the start of vblank, one square per cycle,
// so positions stay frozen while the active area is being painted.
module square_motion_scheduler
  import vga_pkg::*;
#(
  parameter int NUM_SQ = 2,
  parameter int SIZE   = 50,
  parameter int SPEED  = 4,
  parameter int H_RES  = H_ACTIVE,
  parameter int V_RES  = V_ACTIVE,
  parameter logic [NUM_SQ*COORD_W-1:0] START_X = {10'd200, 10'd100},
  parameter logic [NUM_SQ*COORD_W-1:0] START_Y = {10'd400, 10'd100}
) (
  input  logic                        clk_pix,
  input  logic                        rst_pix,
  input  logic [COORD_W-1:0]          sx,
  input  logic [COORD_W-1:0]          sy,
  input  logic                        pause,
  output logic [NUM_SQ*COORD_W-1:0]   pos_x,
  output logic [NUM_SQ*COORD_W-1:0]   pos_y,
  output logic [NUM_SQ-1:0]           dir_x,
  output logic [NUM_SQ-1:0]           dir_y,
  output logic                        busy,
  output logic                        frame_done,
  output logic [15:0]                 frame_count
);
  localparam int IDX_W = (NUM_SQ > 1) ? $clog2(NUM_SQ) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SQ - 1);

  sched_state_t       state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               trigger;
  logic [COORD_W-1:0] cur_x, cur_y, nxt_x, nxt_y;
  logic               cur_dx, cur_dy, nxt_dx, nxt_dy;

  // First pixel of vertical blanking: happens exactly once per frame.
  assign trigger = (sx == '0) && (sy == COORD_W'(V_RES));

  always_comb begin
    cur_x  = '0;
    cur_y  = '0;
    cur_dx = 1'b0;
    cur_dy = 1'b0;
    for (int i = 0; i < NUM_SQ; i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_x  = pos_x[i*COORD_W +: COORD_W];
        cur_y  = pos_y[i*COORD_W +: COORD_W];
        cur_dx = dir_x[i];
        cur_dy = dir_y[i];
      end
    end
  end

  square_axis_step #(.SIZE(SIZE), .SPEED(SPEED), .LIMIT(H_RES)) u_step_x (
    .pos      (cur_x),
    .dir      (cur_dx),
    .pos_next (nxt_x),
    .dir_next (nxt_dx)
  );

  square_axis_step #(.SIZE(SIZE), .SPEED(SPEED), .LIMIT(V_RES)) u_step_y (
    .pos      (cur_y),
    .dir      (cur_dy),
    .pos_next (nxt_y),
    .dir_next (nxt_dy)
  );

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    busy       = 1'b0;
    frame_done = 1'b0;
    case (state_q)
      IDLE: begin
        // pause is only looked at here; a running sequence always completes.
        if (trigger && !pause) begin
          state_d = STEP;
          idx_d   = '0;
        end
      end
      STEP: begin
        busy = 1'b1;
        if (idx_q == LAST_IDX) state_d = DONE;
        else                   idx_d   = idx_q + 1'b1;
      end
      DONE: begin
        frame_done = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_pix or posedge rst_pix) begin
    if (rst_pix) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      frame_count <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (state_q == DONE) frame_count <= frame_count + 16'd1;
    end
  end

  always_ff @(posedge clk_pix or posedge rst_pix) begin
    if (rst_pix) begin
      pos_x <= START_X;
      pos_y <= START_Y;
      dir_x <= '1;
      dir_y <= '1;
    end else if (state_q == STEP) begin
      for (int i = 0; i < NUM_SQ; i++) begin
        if (idx_q == IDX_W'(i)) begin
          pos_x[i*COORD_W +: COORD_W] <= nxt_x;
          pos_y[i*COORD_W +: COORD_W] <= nxt_y;
          dir_x[i]                    <= nxt_dx;
          dir_y[i]                    <= nxt_dy;
        end
      end
    end
  end
endmodule
